// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the DE2 hex keypad entry path: debounce
// FSM states, key-to-action mapping and digit width.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } db_state_e;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_CLEAR  = 0;
    localparam int KEY_ENTER  = 1;
    localparam int KEY_BACK   = 2;
    localparam int KEY_COMMIT = 3;

    localparam int DIGIT_W = 4;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchronizer, four-state debounce FSM with a
// stability counter, debounced level and a one-cycle press pulse.
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer resets to the released level so reset never looks like a press.
    logic [1:0]       sync_reg;
    db_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_reg, press_next;
    logic             key_low;

    assign key_low = ~sync_reg[1];
    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            state_reg <= UP;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_raw};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            press_reg <= press_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        press_next = 1'b0;
        case (state_reg)
            UP: begin
                if (key_low) begin
                    state_next = WAIT_DOWN;
                    cnt_next   = '0;
                end
            end
            WAIT_DOWN: begin
                if (!key_low) begin
                    state_next = UP;
                    cnt_next   = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    state_next = DOWN;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DOWN: begin
                if (!key_low) begin
                    state_next = WAIT_UP;
                    cnt_next   = '0;
                end
            end
            WAIT_UP: begin
                if (key_low) begin
                    state_next = DOWN;
                    cnt_next   = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    state_next = UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = UP;
                cnt_next   = '0;
            end
        endcase
    end

    // Level and pulse change together because both come from the same edge.
    assign key_level = (state_reg == DOWN) || (state_reg == WAIT_UP);
    assign key_press = press_reg;

endmodule

// File: rtl/hex_entry.sv
// Hex value entry from DE2 keys and switches: debounced key actions build a
// shift register of nibbles which is committed to the CPU/display path.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_DIGITS      = 8
) (
    input  logic                            CLOCK_50,
    input  logic                            rst_n,
    input  logic [3:0]                      KEY,
    input  logic [17:0]                     SW,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   entry,
    output logic [3:0]                      digit_count,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   committed,
    output logic                            commit_strobe,
    output logic [3:0]                      key_state
);

    localparam int         VAL_W = DIGIT_W * NUM_DIGITS;
    localparam logic [3:0] FULL  = 4'(NUM_DIGITS);

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk       (CLOCK_50),
                .rst_n     (rst_n),
                .key_raw   (KEY[gi]),
                .key_level (level[gi]),
                .key_press (press[gi])
            );
        end
    endgenerate

    assign key_state = level;

    // Only the low nibble of the switch bank carries a digit.
    logic sw_unused;
    assign sw_unused = ^SW[17:4];

    logic [DIGIT_W-1:0] sw_meta_reg, sw_sync_reg;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= SW[DIGIT_W-1:0];
            sw_sync_reg <= sw_meta_reg;
        end
    end

    logic [VAL_W-1:0] entry_reg, entry_next;
    logic [VAL_W-1:0] committed_reg, committed_next;
    logic [3:0]       count_reg, count_next;
    logic             strobe_reg, strobe_next;

    // Priority: clear > commit > backspace > enter; lower ones are dropped.
    always_comb begin
        entry_next     = entry_reg;
        committed_next = committed_reg;
        count_next     = count_reg;
        strobe_next    = 1'b0;
        if (press[KEY_CLEAR]) begin
            entry_next = '0;
            count_next = '0;
        end else if (press[KEY_COMMIT]) begin
            committed_next = entry_reg;
            strobe_next    = 1'b1;
            entry_next     = '0;
            count_next     = '0;
        end else if (press[KEY_BACK]) begin
            entry_next = entry_reg >> DIGIT_W;
            count_next = (count_reg == 4'd0) ? 4'd0 : count_reg - 4'd1;
        end else if (press[KEY_ENTER]) begin
            entry_next = {entry_reg[VAL_W-DIGIT_W-1:0], sw_sync_reg};
            count_next = (count_reg >= FULL) ? FULL : count_reg + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            entry_reg     <= '0;
            committed_reg <= '0;
            count_reg     <= '0;
            strobe_reg    <= 1'b0;
        end else begin
            entry_reg     <= entry_next;
            committed_reg <= committed_next;
            count_reg     <= count_next;
            strobe_reg    <= strobe_next;
        end
    end

    assign entry         = entry_reg;
    assign committed     = committed_reg;
    assign digit_count   = count_reg;
    assign commit_strobe = strobe_reg;

endmodule

// File: doc/hex_entry.md
# hex_entry

User-input front end for the DE2 board: the reverse direction of the seven-segment output path. It synchronizes and debounces the push-buttons, samples the switch nibble, and builds up a 32-bit hexadecimal value one digit at a time. On commit it presents the value, with a one-cycle strobe, to the CPU I/O logic and to the HEX display driver inside `top`.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz); benches override with 4.
- NUM_DIGITS, 8, maximum digits held in the entry register (value width = 4*NUM_DIGITS).

Ports:
- Clock and reset: one clock, `CLOCK_50`; reset `rst_n` is asynchronous and active-low.
- CLOCK_50  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- KEY  input  4  raw push-buttons, active-low (0 = pressed), asynchronous.
- SW  input  18  raw switches, asynchronous; only SW[3:0] is used, SW[17:4] is ignored.
- entry  output  32  digits entered so far, least-significant nibble is the newest digit.
- digit_count  output  4  number of digits in entry, 0..NUM_DIGITS.
- committed  output  32  last committed value.
- commit_strobe  output  1  one-cycle pulse when committed updates.
- key_state  output  4  debounced key levels, active-high (1 = pressed).

## Operation
- Synchronization: KEY[3:0] and SW[3:0] each pass through two flops. KEY synchronizer flops reset to 1 (released); SW flops reset to 0.
- Debounce: there is one FSM per key, with states UP, WAIT_DOWN, DOWN, WAIT_UP.
  - UP: synced key low -> WAIT_DOWN, counter cleared.
  - WAIT_DOWN: counter increments while the synced key stays low. The key returning high -> UP. Counter reaching DEBOUNCE_CYCLES-1 -> DOWN, and a one-cycle press event is emitted.
  - DOWN and WAIT_UP: the symmetric release path. No event is emitted on release.
- Key actions on a press event:
  - KEY0 = clear: entry <= 0, digit_count <= 0.
  - KEY1 = enter: entry <= {entry[27:0], SW_sync[3:0]}; digit_count <= min(digit_count+1, NUM_DIGITS). When already full, the oldest nibble is shifted out and the count stays at 8.
  - KEY2 = backspace: entry <= entry >> 4; digit_count <= max(digit_count-1, 0). On an empty entry it is a no-op (entry stays 0).
  - KEY3 = commit: committed <= entry, commit_strobe = 1, then entry and digit_count are cleared. Committing an empty entry commits 0 and still strobes.
- Simultaneous press events in one cycle: only the highest-priority action executes. Priority is clear > commit > backspace > enter.
- Reset values: entry = 0, digit_count = 0, committed = 0, commit_strobe = 0, key_state = 0, all FSMs in UP, counters 0.
- Reset mid-debounce: the pending event is discarded. A key held through reset release is treated as a fresh press and yields an event after the full debounce.

## Timing
- Raw KEY going low at edge t is synced at edge t+2.
- The press event is high in the cycle after edge t+1+DEBOUNCE_CYCLES.
- entry, digit_count, committed and commit_strobe update on the following edge. Total latency is DEBOUNCE_CYCLES+3 edges from the raw transition.
- A glitch of fewer than DEBOUNCE_CYCLES synced cycles produces no event and no key_state change.
- key_state changes in the same cycle as the corresponding event.
- commit_strobe is high for exactly one cycle per commit, even while KEY3 is held.
- SW_sync is sampled in the action cycle. SW changes during debounce affect only the nibble captured at that cycle.

## Structure
- Shared package `hex_entry_pkg`:
  - debounce state enum (UP, WAIT_DOWN, DOWN, WAIT_UP);
  - key index constants KEY_CLEAR=0, KEY_ENTER=1, KEY_BACK=2, KEY_COMMIT=3;
  - DIGIT_W=4.
- Sub-module `key_debounce`: one per key, containing the synchronizer, FSM, counter, level output and press pulse. It is parameterized by DEBOUNCE_CYCLES.
- hex_entry itself instantiates four key_debounce blocks and holds the SW synchronizer, the priority action logic and the registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert rst_n=0 mid-cycle with keys released -> all outputs 0 immediately; after release no events occur while KEY=4'hF.
- Digit entry: SW[3:0]=C, press KEY1; then SW=D, press KEY1 -> entry=32'h0000_00CD, digit_count=2. The first update lands exactly 7 edges after the raw press.
- Glitch rejection: pulse KEY1 low for 3 synced cycles -> no entry change, key_state[1] stays 0. A press held for 4 cycles is accepted.
- Overflow and backspace:
  - Enter nine digits 1..9 -> entry=32'h2345_6789, digit_count=8.
  - Backspace -> 32'h0234_5678, digit_count=7.
  - Backspace on an empty entry -> stays 0, count 0.
- Commit: with entry=32'hFEDC, press KEY3 and hold 20 cycles -> committed=32'h0000_FEDC, exactly one commit_strobe cycle, entry=0, digit_count=0.
- Simultaneous events: KEY1 and KEY3 pressed on the same edge with entry=32'hAB -> commit wins (committed=32'hAB, entry=0). Also verify KEY0 together with KEY3 -> clear only, no strobe.
